// File: rtl/task_ctrl_block_p.sv
// Hardware task control block: lifecycle state, priority aging,
// execution budget and sorter entry for one scheduler task.
module task_ctrl_block_p #(
   parameter int TASK_ID    = 9,
   parameter int ID_W       = 8,
   parameter int PRIO_W     = 8,
   parameter int HIT_W      = 8,
   parameter int ARG_W      = 8,
   parameter int AGE_PERIOD = 10000,
   parameter int CNT_W      = 32,
   parameter int INIT_HIT   = 128
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    op_valid,
   input  logic [ID_W+4+ARG_W-1:0] in_op,
   output logic [ID_W+PRIO_W-1:0]  out_sorter,
   output logic                    out_valid,
   output logic                    exe_flag,
   output logic                    op_ack,
   output logic                    op_err,
   output logic [1:0]              state_o
);

   typedef enum logic [1:0] {
      ST_READY = 2'b00,
      ST_SUSP  = 2'b01,
      ST_WAIT  = 2'b10,
      ST_TERM  = 2'b11
   } state_t;

   state_t             state, state_n;
   logic [PRIO_W-1:0]  prio, prio_n;
   logic [HIT_W-1:0]   hit, hit_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               exe, exe_n;
   logic               ack_n, err_n;
   logic               aging, tick, sel;
   logic [ID_W+PRIO_W-1:0] sorter_n;

   logic [ID_W-1:0]    tgt;
   logic [3:0]         opc;
   logic [ARG_W-1:0]   arg;

   assign tgt = in_op[ID_W+4+ARG_W-1 -: ID_W];
   assign opc = in_op[ARG_W+3:ARG_W];
   assign arg = in_op[ARG_W-1:0];
   assign sel = op_valid && (tgt == ID_W'(TASK_ID));

   assign aging = (state == ST_READY) && !exe;
   assign tick  = aging && (cnt == CNT_W'(AGE_PERIOD - 1));

   always_comb begin
      state_n  = state;
      prio_n   = prio;
      hit_n    = hit;
      exe_n    = exe;
      cnt_n    = '0;
      ack_n    = 1'b0;
      err_n    = 1'b0;
      sorter_n = '0;

      // Aging first; an accepted SetPrio below overrides the tick.
      if (aging) begin
         if (tick) begin
            cnt_n = '0;
            if (prio != '1) prio_n = prio + 1'b1;
         end else begin
            cnt_n = cnt + 1'b1;
         end
      end

      if (sel) begin
         unique case (opc)
            4'h1, 4'h2, 4'h3: begin
               if (state == ST_TERM) begin
                  err_n = 1'b1;
               end else begin
                  exe_n = 1'b0;
                  unique case (opc)
                     4'h1:    state_n = ST_READY;
                     4'h2:    state_n = ST_SUSP;
                     default: state_n = ST_WAIT;
                  endcase
               end
            end
            4'h4, 4'hC: begin
               state_n = ST_TERM;
               exe_n   = 1'b0;
            end
            4'h5: begin
               if (state == ST_TERM) err_n = 1'b1;
               else prio_n = arg[PRIO_W-1:0];
            end
            4'h6: begin
               if (state == ST_TERM) err_n = 1'b1;
               else hit_n = arg[HIT_W-1:0];
            end
            4'h7: begin
               if (state == ST_READY && !exe && hit != '0) begin
                  hit_n = hit - 1'b1;
                  exe_n = 1'b1;
               end else begin
                  err_n = 1'b1;
               end
            end
            4'hF: begin
               if (exe && state != ST_TERM) exe_n = 1'b0;
               else err_n = 1'b1;
            end
            default: err_n = 1'b1;
         endcase
         ack_n = !err_n;
      end

      // Leaving Ready or starting execution restarts the aging period.
      if (state_n != ST_READY || exe_n) cnt_n = '0;

      if (aging) sorter_n = {ID_W'(TASK_ID), prio};
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= ST_READY;
         prio       <= '0;
         hit        <= HIT_W'(INIT_HIT);
         exe        <= 1'b0;
         cnt        <= '0;
         op_ack     <= 1'b0;
         op_err     <= 1'b0;
         out_sorter <= '0;
         out_valid  <= 1'b0;
      end else begin
         state      <= state_n;
         prio       <= prio_n;
         hit        <= hit_n;
         exe        <= exe_n;
         cnt        <= cnt_n;
         op_ack     <= ack_n;
         op_err     <= err_n;
         out_sorter <= sorter_n;
         out_valid  <= aging;
      end
   end

   assign exe_flag = exe;
   assign state_o  = state;

endmodule

// File: tb/tb_task_ctrl_block_p.sv
// Directed bench for task_ctrl_block_p: command table on one instance,
// aging timeline on a second instance with a short aging period.
module tb_task_ctrl_block_p;

   logic        CLK = 1'b0;
   logic        RST;
   logic        op_valid;
   logic [19:0] in_op;
   logic [15:0] out_sorter;
   logic        out_valid, exe_flag, op_ack, op_err;
   logic [1:0]  state_o;

   logic        rst_a;
   logic        op_valid_a;
   logic [19:0] in_op_a;
   logic [15:0] out_sorter_a;
   logic        out_valid_a, exe_flag_a, op_ack_a, op_err_a;
   logic [1:0]  state_o_a;

   int checks = 0;
   int failures = 0;

   always #5 CLK = ~CLK;

   task_ctrl_block_p dut (
      .CLK(CLK), .RST(RST), .op_valid(op_valid), .in_op(in_op),
      .out_sorter(out_sorter), .out_valid(out_valid),
      .exe_flag(exe_flag), .op_ack(op_ack), .op_err(op_err),
      .state_o(state_o)
   );

   task_ctrl_block_p #(.AGE_PERIOD(4)) dut_a (
      .CLK(CLK), .RST(rst_a), .op_valid(op_valid_a), .in_op(in_op_a),
      .out_sorter(out_sorter_a), .out_valid(out_valid_a),
      .exe_flag(exe_flag_a), .op_ack(op_ack_a), .op_err(op_err_a),
      .state_o(state_o_a)
   );

   typedef struct {
      logic        v;
      logic [19:0] op;
      logic        exe;
      logic        ack;
      logic        err;
      logic [1:0]  st;
      logic        ov;
      logic [15:0] os;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input logic v, input logic [19:0] op,
                      input logic exe, input logic ack, input logic err,
                      input logic [1:0] st, input logic ov,
                      input logic [15:0] os);
      vec_t r;
      r.v = v; r.op = op; r.exe = exe; r.ack = ack; r.err = err;
      r.st = st; r.ov = ov; r.os = os;
      tv.push_back(r);
   endtask

   task automatic chk_main(input string name, input vec_t r);
      chk({name, "_exe"}, 32'(exe_flag), 32'(r.exe));
      chk({name, "_ack"}, 32'(op_ack), 32'(r.ack));
      chk({name, "_err"}, 32'(op_err), 32'(r.err));
      chk({name, "_st"}, 32'(state_o), 32'(r.st));
      chk({name, "_ov"}, 32'(out_valid), 32'(r.ov));
      chk({name, "_os"}, 32'(out_sorter), 32'(r.os));
   endtask

   initial begin
      vec_t r;
      RST = 1'b1; op_valid = 1'b0; in_op = '0;
      rst_a = 1'b1; op_valid_a = 1'b0; in_op_a = '0;

      //   v  op        exe ack err st  ov  os
      add(0, 20'h00000, 0, 0, 0, 2'd0, 1, 16'h0900);
      add(0, 20'h00000, 0, 0, 0, 2'd0, 1, 16'h0900);
      add(0, 20'h00000, 0, 0, 0, 2'd0, 1, 16'h0900);
      add(1, 20'h09700, 1, 1, 0, 2'd0, 1, 16'h0900);
      add(0, 20'h00000, 1, 0, 0, 2'd0, 0, 16'h0000);
      add(1, 20'h09F00, 0, 1, 0, 2'd0, 0, 16'h0000);
      add(0, 20'h00000, 0, 0, 0, 2'd0, 1, 16'h0900);
      add(1, 20'h09533, 0, 1, 0, 2'd0, 1, 16'h0900);
      add(0, 20'h00000, 0, 0, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09F00, 0, 0, 1, 2'd0, 1, 16'h0933);
      add(1, 20'h09800, 0, 0, 1, 2'd0, 1, 16'h0933);
      add(1, 20'h0A700, 0, 0, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09600, 0, 1, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09700, 0, 0, 1, 2'd0, 1, 16'h0933);
      add(1, 20'h09602, 0, 1, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09700, 1, 1, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09700, 1, 0, 1, 2'd0, 0, 16'h0000);
      add(1, 20'h09200, 0, 1, 0, 2'd1, 0, 16'h0000);
      add(1, 20'h09700, 0, 0, 1, 2'd1, 0, 16'h0000);
      add(1, 20'h09100, 0, 1, 0, 2'd0, 0, 16'h0000);
      add(1, 20'h09700, 1, 1, 0, 2'd0, 1, 16'h0933);
      add(1, 20'h09300, 0, 1, 0, 2'd2, 0, 16'h0000);
      add(1, 20'h09100, 0, 1, 0, 2'd0, 0, 16'h0000);
      add(1, 20'h09700, 0, 0, 1, 2'd0, 1, 16'h0933);
      add(1, 20'h09400, 0, 1, 0, 2'd3, 1, 16'h0933);
      add(1, 20'h09100, 0, 0, 1, 2'd3, 0, 16'h0000);
      add(1, 20'h09577, 0, 0, 1, 2'd3, 0, 16'h0000);
      add(1, 20'h09C00, 0, 1, 0, 2'd3, 0, 16'h0000);
      add(1, 20'h09F00, 0, 0, 1, 2'd3, 0, 16'h0000);
      add(0, 20'h09100, 0, 0, 0, 2'd3, 0, 16'h0000);

      repeat (2) @(posedge CLK);
      #1;
      r = '{v: 0, op: 0, exe: 0, ack: 0, err: 0, st: 0, ov: 0, os: 0};
      chk_main("reset", r);
      chk("reset_a_ov", 32'(out_valid_a), 32'd0);

      @(negedge CLK);
      RST = 1'b0;
      foreach (tv[i]) begin
         op_valid = tv[i].v;
         in_op    = tv[i].op;
         @(posedge CLK);
         #1;
         chk_main($sformatf("vec%0d", i), tv[i]);
         @(negedge CLK);
      end

      // Reset out of Terminated with budget exhausted.
      op_valid = 1'b0; in_op = '0; RST = 1'b1;
      @(posedge CLK);
      #1;
      r = '{v: 0, op: 0, exe: 0, ack: 0, err: 0, st: 0, ov: 0, os: 0};
      chk_main("rst_term", r);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
      r.ov = 1'b1; r.os = 16'h0900;
      chk_main("rst_rel", r);
      @(negedge CLK);
      op_valid = 1'b1; in_op = 20'h09700;
      @(posedge CLK);
      #1;
      r.exe = 1'b1; r.ack = 1'b1;
      chk_main("rst_hit", r);
      @(negedge CLK);
      op_valid = 1'b0; in_op = '0;

      // Aging timeline, AGE_PERIOD = 4.
      rst_a = 1'b0;
      for (int e = 1; e <= 49; e++) begin
         op_valid_a = 1'b1;
         case (e)
            14:      in_op_a = 20'h09700;
            21:      in_op_a = 20'h09200;
            28:      in_op_a = 20'h09100;
            34:      in_op_a = 20'h095FE;
            44:      in_op_a = 20'h09510;
            default: begin op_valid_a = 1'b0; in_op_a = '0; end
         endcase
         @(posedge CLK);
         #1;
         if (e <= 13)
            chk($sformatf("age_ramp%0d", e), 32'(out_sorter_a),
                {16'h0, 8'h09, 8'((e - 1) / 4)});
         case (e)
            14: chk("age_start_exe", 32'(exe_flag_a), 32'd1);
            20: chk("age_run_os", 32'(out_sorter_a), 32'h0);
            21: chk("age_susp_st", 32'(state_o_a), 32'd1);
            27: chk("age_susp_ov", 32'(out_valid_a), 32'd0);
            29: chk("age_resume", 32'(out_sorter_a), 32'h0903);
            32: chk("age_hold", 32'(out_sorter_a), 32'h0903);
            33: chk("age_tick", 32'(out_sorter_a), 32'h0904);
            37: chk("age_sat1", 32'(out_sorter_a), 32'h09FF);
            41: chk("age_sat2", 32'(out_sorter_a), 32'h09FF);
            42: chk("age_sat3", 32'(out_sorter_a), 32'h09FF);
            45: chk("age_setwin", 32'(out_sorter_a), 32'h0910);
            48: chk("age_wrap", 32'(out_sorter_a), 32'h0910);
            49: chk("age_next", 32'(out_sorter_a), 32'h0911);
            default: ;
         endcase
         @(negedge CLK);
      end
      op_valid_a = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
